irq_encoder_83: RTL and testbench
=================================

IRQ_ENCODER_83 -- requirements
Module: irq_encoder_83

Interface
REQ-001: Port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002: Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003: Port req_n, input, 8 bits: asynchronous active-low request lines; line i requests when low.
REQ-004: Port mask_we, input, 1 bit: mask write strobe.
REQ-005: Port mask_in, input, 8 bits: mask write data; bit i = 1 masks line i.
REQ-006: Port ack, input, 1 bit: one-cycle acknowledge of the presented request.
REQ-007: Port irq, output, 1 bit: a request is presented; registered.
REQ-008: Port irq_num, output, 3 bits: index of the presented line; registered.
REQ-009: Port mask_out, output, 8 bits: current mask register contents.

Function
REQ-010: Each req_n bit SHALL pass through a 2-flop synchronizer (s1, s2) followed by a history flop s3.
REQ-011: A falling edge on line i SHALL be detected when s3[i]=1 and s2[i]=0.
REQ-012: A detected edge SHALL set pending[i] on the next rising edge.
REQ-013: Pending bits SHALL be edge-latched, not levels; repeated edges while pending[i]=1 leave a single pending.
REQ-014: The eligible set SHALL be pending & ~mask.
REQ-015: The priority encoder SHALL select the lowest eligible index; line 0 has highest priority.
REQ-016: The FSM SHALL have states IDLE, PRESENT and GAP.
REQ-017: IDLE -> PRESENT when the eligible set is non-zero; irq_num <= selected index; irq <= 1.
REQ-018: In PRESENT, irq_num SHALL stay frozen regardless of new edges, mask writes or higher-priority arrivals.
REQ-019: PRESENT with ack=1 -> GAP; pending[irq_num] cleared; irq <= 0.
REQ-020: GAP SHALL last exactly one cycle with irq=0, then -> IDLE.
REQ-021: ack SHALL be ignored in IDLE and GAP.
REQ-022: If ack clears pending[i] in the same cycle a new edge on line i is detected, the set SHALL win and pending[i] stays 1.
REQ-023: mask_we=1 SHALL load mask <= mask_in on that edge; mask_out reflects it the next cycle.
REQ-024: Masking the presented line while in PRESENT SHALL NOT retract irq; ack still completes normally.
REQ-025: Masked lines SHALL still accumulate pending bits; unmasking makes them eligible.
REQ-026: Latency SHALL be as follows, taking the edge that first samples req_n[i] low as edge 1 with the line unmasked and the FSM idle:
- pending[i] set at edge 3.
- irq=1 at edge 4.

Reset
REQ-027: On reset=1, asynchronously and without waiting for clk, the block SHALL set:
- s1, s2, s3 <= 8'hFF.
- pending <= 0.
- mask <= 8'hFF (all masked).
- state <= IDLE.
- irq <= 0, irq_num <= 0.
REQ-028: Reset asserted mid-PRESENT SHALL drop irq immediately and discard all pending requests.
REQ-029: Lines held low through reset release SHALL NOT generate an edge; a new high-to-low transition is required.

Verification
REQ-030: Reset, mask_we with mask_in=8'h00, then req_n=8'hF7 -> irq=1, irq_num=3 exactly 4 edges after sampling; mask_out=8'h00.
REQ-031: Lines 5 and 2 fall in the same cycle -> irq_num=2; ack -> 1-cycle GAP with irq=0 -> irq_num=5; second ack -> IDLE, irq=0.
REQ-032: While presenting line 6, line 1 falls -> irq_num stays 6 until ack; after GAP, irq_num=1.
REQ-033: Mask=8'h10 with line 4 falling -> irq stays 0 and pending[4]=1; write mask=8'h00 -> irq_num=4 two edges later.
REQ-034: A line 3 edge detected in the same cycle as ack of line 3 -> after GAP, irq_num=3 is re-presented.
REQ-035: Reset pulse mid-PRESENT with req_n held 8'h00 -> irq=0 at once; after release and mask=8'h00, irq stays 0 until a line rises and falls again.

Source files
------------

// File: rtl/irq_encoder_83.sv
// irq_encoder_83: edge-latched 8-line interrupt encoder with mask and ack.
// Ports: clk, reset (async high), req_n[7:0] (async, active low),
//   mask_we/mask_in[7:0] (mask write), ack (accept presented request),
//   irq/irq_num[2:0] (registered presentation), mask_out[7:0] (mask reg).
module irq_encoder_83 (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] req_n,
   input  logic       mask_we,
   input  logic [7:0] mask_in,
   input  logic       ack,
   output logic       irq,
   output logic [2:0] irq_num,
   output logic [7:0] mask_out
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      GAP     = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] s1;
   logic [7:0] s2;
   logic [7:0] s3;
   logic [7:0] pending;
   logic [7:0] pending_nxt;
   logic [7:0] mask;
   logic [7:0] fall;
   logic [7:0] elig;
   logic [7:0] clr;
   logic [1:0] warm;
   logic       any;
   logic [2:0] sel;
   logic       irq_nxt;
   logic [2:0] num_nxt;

   // Synchronizer plus history flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= 8'hFF;
         s2 <= 8'hFF;
         s3 <= 8'hFF;
      end else begin
         s1 <= req_n;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Edge detection stays off until s3 and s2 both hold real samples,
   // so a line held low across reset release never looks like an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         warm <= 2'd0;
      end else if (warm != 2'd3) begin
         warm <= warm + 2'd1;
      end
   end

   assign fall = (warm == 2'd3) ? (s3 & ~s2) : 8'h00;
   assign elig = pending & ~mask;
   assign any  = |elig;

   // Lowest eligible index wins.
   always_comb begin
      sel = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (elig[i]) begin
            sel = i[2:0];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      irq_nxt   = irq;
      num_nxt   = irq_num;
      clr       = 8'h00;
      unique case (state)
         IDLE: begin
            if (any) begin
               state_nxt = PRESENT;
               irq_nxt   = 1'b1;
               num_nxt   = sel;
            end
         end
         PRESENT: begin
            if (ack) begin
               state_nxt = GAP;
               irq_nxt   = 1'b0;
               clr       = 8'h01 << irq_num;
            end
         end
         GAP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            irq_nxt   = 1'b0;
         end
      endcase
   end

   // A new edge in the same cycle as the clearing ack keeps the bit set.
   assign pending_nxt = (pending & ~clr) | fall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         irq     <= 1'b0;
         irq_num <= 3'd0;
         pending <= 8'h00;
      end else begin
         state   <= state_nxt;
         irq     <= irq_nxt;
         irq_num <= num_nxt;
         pending <= pending_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask <= 8'hFF;
      end else if (mask_we) begin
         mask <= mask_in;
      end
   end

   assign mask_out = mask;

endmodule

// File: tb/tb_irq_encoder_83.sv
// tb_irq_encoder_83: directed checks of irq_encoder_83.
// Drives inputs 1ns after each rising edge and checks there.
module tb_irq_encoder_83;

   logic       clk;
   logic       reset;
   logic [7:0] req_n;
   logic       mask_we;
   logic [7:0] mask_in;
   logic       ack;
   logic       irq;
   logic [2:0] irq_num;
   logic [7:0] mask_out;

   int tests;
   int fails;

   irq_encoder_83 dut (
      .clk      (clk),
      .reset    (reset),
      .req_n    (req_n),
      .mask_we  (mask_we),
      .mask_in  (mask_in),
      .ack      (ack),
      .irq      (irq),
      .irq_num  (irq_num),
      .mask_out (mask_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write_mask(input logic [7:0] m);
      mask_we = 1'b1;
      mask_in = m;
      tick(1);
      mask_we = 1'b0;
   endtask

   task automatic do_ack;
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      reset   = 1'b0;
      req_n   = 8'hFF;
      mask_we = 1'b0;
      mask_in = 8'h00;
      ack     = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_num", {29'd0, irq_num}, 32'd0);
      check("rst_mask", {24'd0, mask_out}, 32'hFF);
      tick(2);
      reset = 1'b0;
      tick(4);

      // Single line 3, latency 4 edges.
      write_mask(8'h00);
      check("mask_out_00", {24'd0, mask_out}, 32'h00);
      req_n = 8'hF7;
      tick(3);
      check("lat_e3_irq", {31'd0, irq}, 32'd0);
      tick(1);
      check("lat_e4_irq", {31'd0, irq}, 32'd1);
      check("lat_e4_num", {29'd0, irq_num}, 32'd3);
      do_ack;
      check("ack3_gap", {31'd0, irq}, 32'd0);
      tick(2);
      check("ack3_level", {31'd0, irq}, 32'd0);
      req_n = 8'hFF;
      tick(3);

      // Lines 5 and 2 together.
      req_n = 8'hDB;
      tick(4);
      check("pair_irq", {31'd0, irq}, 32'd1);
      check("pair_num2", {29'd0, irq_num}, 32'd2);
      do_ack;
      check("pair_gap", {31'd0, irq}, 32'd0);
      tick(1);
      check("pair_idle", {31'd0, irq}, 32'd0);
      tick(1);
      check("pair_irq5", {31'd0, irq}, 32'd1);
      check("pair_num5", {29'd0, irq_num}, 32'd5);
      do_ack;
      tick(2);
      check("pair_done", {31'd0, irq}, 32'd0);
      req_n = 8'hFF;
      tick(3);

      // Line 6 presented, line 1 arrives: frozen.
      req_n = 8'hBF;
      tick(4);
      check("frz_num6", {29'd0, irq_num}, 32'd6);
      req_n = 8'hBD;
      tick(5);
      check("frz_irq", {31'd0, irq}, 32'd1);
      check("frz_still6", {29'd0, irq_num}, 32'd6);
      do_ack;
      tick(2);
      check("frz_irq1", {31'd0, irq}, 32'd1);
      check("frz_num1", {29'd0, irq_num}, 32'd1);
      do_ack;
      tick(2);
      req_n = 8'hFF;
      tick(3);

      // Masked line 4 accumulates pending.
      write_mask(8'h10);
      req_n = 8'hEF;
      tick(5);
      check("msk_irq", {31'd0, irq}, 32'd0);
      check("msk_pend4", {31'd0, dut.pending[4]}, 32'd1);
      write_mask(8'h00);
      check("unmsk_e1", {31'd0, irq}, 32'd0);
      tick(1);
      check("unmsk_irq", {31'd0, irq}, 32'd1);
      check("unmsk_num4", {29'd0, irq_num}, 32'd4);
      do_ack;
      tick(2);
      req_n = 8'hFF;
      tick(3);

      // Edge on line 3 coincides with its ack.
      req_n = 8'hF7;
      tick(4);
      check("race_num3", {29'd0, irq_num}, 32'd3);
      req_n = 8'hFF;
      tick(3);
      req_n = 8'hF7;
      tick(2);
      do_ack;
      check("race_gap", {31'd0, irq}, 32'd0);
      check("race_pend3", {31'd0, dut.pending[3]}, 32'd1);
      tick(2);
      check("race_irq", {31'd0, irq}, 32'd1);
      check("race_renum3", {29'd0, irq_num}, 32'd3);

      // Reset mid-PRESENT with all lines low.
      req_n = 8'h00;
      tick(1);
      reset = 1'b1;
      #1;
      check("mid_rst_irq", {31'd0, irq}, 32'd0);
      check("mid_rst_pend", {24'd0, dut.pending}, 32'd0);
      tick(1);
      reset = 1'b0;
      tick(4);
      write_mask(8'h00);
      tick(6);
      check("held_low_irq", {31'd0, irq}, 32'd0);
      check("held_low_pend", {24'd0, dut.pending}, 32'd0);
      req_n = 8'h01;
      tick(3);
      check("rise_irq", {31'd0, irq}, 32'd0);
      req_n = 8'h00;
      tick(4);
      check("refall_irq", {31'd0, irq}, 32'd1);
      check("refall_num0", {29'd0, irq_num}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
